// File: rtl/cmp_pkg.sv
// Shared types and constants for the serial magnitude comparator.
// Flag layout matches the external 4-bit comparator output.
package cmp_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_t;

    localparam int FLAG_EQ  = 0;
    localparam int FLAG_LT  = 1;
    localparam int FLAG_GT  = 2;
    localparam int FLAG_RSV = 3;

    localparam logic [3:0] CODE_EQ = 4'b0001;
    localparam logic [3:0] CODE_LT = 4'b0010;
    localparam logic [3:0] CODE_GT = 4'b0100;

    function automatic int idx_w(input int nib);
        return (nib > 1) ? $clog2(nib) : 1;
    endfunction

endpackage

// File: rtl/serial_magnitude_compare_if.sv
// Request/result handshake bundle for the serial comparator.
// master = requester/consumer, slave = comparator block.
interface serial_magnitude_compare_if #(
    parameter int WIDTH = 16
);
    localparam int NIB = WIDTH / 4;
    localparam int CW  = $clog2(NIB + 1);

    logic             start_valid;
    logic             start_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             signed_mode;
    logic             res_valid;
    logic             res_ready;
    logic [3:0]       res_flags;
    logic [CW-1:0]    res_count;
    logic             res_err;

    modport master (
        output start_valid, a, b, signed_mode, res_ready,
        input  start_ready, res_valid, res_flags, res_count, res_err
    );

    modport slave (
        input  start_valid, a, b, signed_mode, res_ready,
        output start_ready, res_valid, res_flags, res_count, res_err
    );

endinterface

// File: rtl/nibble_select.sv
// Combinational nibble picker: returns vec[4*idx+3:4*idx].
// Out-of-range idx yields zero.
module nibble_select
    import cmp_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0]              vec,
    input  logic [idx_w(WIDTH/4)-1:0]     idx,
    output logic [3:0]                    nib
);
    localparam int NIB = WIDTH / 4;
    localparam int IW  = idx_w(NIB);

    // One-hot match of idx against each nibble position
    always_comb begin
        nib = '0;
        for (int i = 0; i < NIB; i++) begin
            if (idx == IW'(i)) nib = vec[4*i +: 4];
        end
    end

endmodule

// File: rtl/serial_magnitude_compare.sv
// Multi-cycle magnitude compare, MSB nibble first, early exit.
// Signed mode biases the sign bit so the unsigned scan gives signed order.
module serial_magnitude_compare
    import cmp_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    serial_magnitude_compare_if.slave bus,
    output logic [3:0]                cmp_a,
    output logic [3:0]                cmp_b,
    input  logic [3:0]                cmp_y
);
    localparam int NIB = WIDTH / 4;
    localparam int CW  = $clog2(NIB + 1);
    localparam int IW  = idx_w(NIB);

    state_t           state;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [IW-1:0]    idx;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] bias;
    logic [3:0]       sel_a;
    logic [3:0]       sel_b;

    nibble_select #(.WIDTH(WIDTH)) u_sel_a (
        .vec (a_r),
        .idx (idx),
        .nib (sel_a)
    );

    nibble_select #(.WIDTH(WIDTH)) u_sel_b (
        .vec (b_r),
        .idx (idx),
        .nib (sel_b)
    );

    assign bus.start_ready = (state == IDLE);
    assign bus.res_valid   = (state == DONE);
    assign cmp_a = (state == SCAN) ? sel_a : 4'h0;
    assign cmp_b = (state == SCAN) ? sel_b : 4'h0;

    // Sign-bit flip mask applied to both operands at capture
    always_comb begin
        bias = '0;
        bias[WIDTH-1] = bus.signed_mode;
    end

    // Capture, nibble scan and result hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            a_r           <= '0;
            b_r           <= '0;
            idx           <= '0;
            cnt           <= '0;
            bus.res_flags <= '0;
            bus.res_count <= '0;
            bus.res_err   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.start_valid) begin
                        a_r   <= bus.a ^ bias;
                        b_r   <= bus.b ^ bias;
                        idx   <= IW'(NIB - 1);
                        cnt   <= '0;
                        state <= SCAN;
                    end
                end
                SCAN: begin
                    cnt <= cnt + CW'(1);
                    unique case (cmp_y)
                        CODE_EQ: begin
                            if (idx != '0) begin
                                idx <= idx - IW'(1);
                            end else begin
                                bus.res_flags <= CODE_EQ;
                                bus.res_err   <= 1'b0;
                                bus.res_count <= cnt + CW'(1);
                                state         <= DONE;
                            end
                        end
                        CODE_LT, CODE_GT: begin
                            bus.res_flags <= cmp_y;
                            bus.res_err   <= 1'b0;
                            bus.res_count <= cnt + CW'(1);
                            state         <= DONE;
                        end
                        default: begin
                            bus.res_flags <= '0;
                            bus.res_err   <= 1'b1;
                            bus.res_count <= cnt + CW'(1);
                            state         <= DONE;
                        end
                    endcase
                end
                DONE: begin
                    if (bus.res_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_magnitude_compare.sv
// Bench for serial_magnitude_compare with a behavioural 4-bit comparator.
// Directed plan cases plus random operands against an integer model.
module tb_serial_magnitude_compare;

    localparam int WIDTH = 16;
    localparam int NIB   = WIDTH / 4;

    logic       clk;
    logic       rst_n;
    logic [3:0] cmp_a;
    logic [3:0] cmp_b;
    logic [3:0] cmp_y;
    logic       inj;
    logic [3:0] inj_val;

    int vectors;
    int miscompares;

    serial_magnitude_compare_if #(.WIDTH(WIDTH)) bus ();

    serial_magnitude_compare #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .cmp_a (cmp_a),
        .cmp_b (cmp_b),
        .cmp_y (cmp_y)
    );

    assign cmp_y = inj ? inj_val
                 : {1'b0, cmp_a > cmp_b, cmp_a < cmp_b, cmp_a == cmp_b};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void ref_cmp(
        input  logic [15:0] a,
        input  logic [15:0] b,
        input  logic        sm,
        output logic [3:0]  fl,
        output int          n
    );
        int ai;
        int bi;
        ai = sm ? int'({{16{a[15]}}, a}) : int'({16'b0, a});
        bi = sm ? int'({{16{b[15]}}, b}) : int'({16'b0, b});
        fl = (ai > bi) ? 4'b0100 : (ai < bi) ? 4'b0010 : 4'b0001;
        n = 0;
        for (int i = NIB - 1; i >= 0; i--) begin
            n++;
            if (a[4*i +: 4] != b[4*i +: 4]) break;
        end
    endfunction

    task automatic do_req(
        input  logic [15:0] a,
        input  logic [15:0] b,
        input  logic        sm,
        output int          lat,
        output logic [3:0]  fl,
        output int          n,
        output logic        err
    );
        @(negedge clk);
        bus.start_valid = 1'b1;
        bus.a = a;
        bus.b = b;
        bus.signed_mode = sm;
        @(posedge clk);
        #1;
        bus.start_valid = 1'b0;
        lat = -1;
        for (int k = 1; k <= NIB + 4; k++) begin
            @(posedge clk);
            #1;
            if (bus.res_valid) begin
                lat = k;
                break;
            end
        end
        fl  = bus.res_flags;
        n   = int'(bus.res_count);
        err = bus.res_err;
        if (bus.res_ready && lat > 0) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        vectors++;
        if (bus.start_ready !== 1'b1 || bus.res_valid !== 1'b0 ||
            bus.res_flags !== 4'h0 || bus.res_count !== 3'd0 ||
            bus.res_err !== 1'b0 || cmp_a !== 4'h0 || cmp_b !== 4'h0) begin
            miscompares++;
            $display("FAIL reset: rdy=%b vld=%b fl=%h cnt=%0d err=%b ca=%h cb=%h req 1 0 0 0 0 0 0",
                     bus.start_ready, bus.res_valid, bus.res_flags,
                     bus.res_count, bus.res_err, cmp_a, cmp_b);
        end
    endtask

    task automatic check_req(
        input string       name,
        input logic [15:0] a,
        input logic [15:0] b,
        input logic        sm
    );
        int         lat;
        int         n;
        int         en;
        logic [3:0] fl;
        logic [3:0] ef;
        logic       err;
        ref_cmp(a, b, sm, ef, en);
        do_req(a, b, sm, lat, fl, n, err);
        vectors++;
        if (fl !== ef || n !== en || lat !== en || err !== 1'b0) begin
            miscompares++;
            $display("FAIL %s a=%h b=%h s=%b: fl=%b cnt=%0d lat=%0d err=%b req fl=%b cnt=%0d lat=%0d err=0",
                     name, a, b, sm, fl, n, lat, err, ef, en, en);
        end
    endtask

    task automatic test_directed;
        check_req("equal", 16'h1234, 16'h1234, 1'b0);
        check_req("msb_u", 16'h8000, 16'h0001, 1'b0);
        check_req("msb_s", 16'h8000, 16'h0001, 1'b1);
        check_req("lsb_u", 16'h12F0, 16'h12F1, 1'b0);
        check_req("neg1_s", 16'hFFFF, 16'h0000, 1'b1);
        check_req("eq_s", 16'h8F00, 16'h8F00, 1'b1);
    endtask

    task automatic test_random;
        logic [15:0] a;
        logic [15:0] b;
        logic        sm;
        for (int t = 0; t < 40; t++) begin
            a  = 16'($urandom);
            b  = a;
            for (int i = 0; i < NIB; i++) begin
                if ($urandom_range(0, 2) == 0) b[4*i +: 4] = 4'($urandom);
            end
            sm = 1'($urandom);
            check_req("random", a, b, sm);
        end
    endtask

    task automatic test_backpressure;
        int         lat;
        int         n;
        logic [3:0] fl;
        logic       err;
        bus.res_ready = 1'b0;
        do_req(16'h00A0, 16'h0050, 1'b0, lat, fl, n, err);
        vectors++;
        if (lat !== 3 || fl !== 4'b0100 || n !== 3) begin
            miscompares++;
            $display("FAIL bp_first: lat=%0d fl=%b cnt=%0d req 3 0100 3", lat, fl, n);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            bus.start_valid = 1'b1;
            bus.a = 16'hFFFF;
            bus.b = 16'h0000;
            @(posedge clk);
            #1;
            vectors++;
            if (bus.res_valid !== 1'b1 || bus.start_ready !== 1'b0 ||
                bus.res_flags !== 4'b0100 || bus.res_count !== 3'd3) begin
                miscompares++;
                $display("FAIL bp_hold: vld=%b rdy=%b fl=%b cnt=%0d req 1 0 0100 3",
                         bus.res_valid, bus.start_ready, bus.res_flags, bus.res_count);
            end
        end
        @(negedge clk);
        bus.start_valid = 1'b0;
        bus.res_ready = 1'b1;
        @(posedge clk);
        #1;
        vectors++;
        if (bus.res_valid !== 1'b0 || bus.start_ready !== 1'b1 ||
            bus.res_flags !== 4'b0100 || bus.res_count !== 3'd3) begin
            miscompares++;
            $display("FAIL bp_release: vld=%b rdy=%b fl=%b cnt=%0d req 0 1 0100 3",
                     bus.res_valid, bus.start_ready, bus.res_flags, bus.res_count);
        end
        check_req("bp_next", 16'h0001, 16'h0002, 1'b0);
    endtask

    task automatic test_reset_mid;
        int seen;
        @(negedge clk);
        bus.start_valid = 1'b1;
        bus.a = 16'h1234;
        bus.b = 16'h1234;
        bus.signed_mode = 1'b0;
        @(posedge clk);
        #1;
        bus.start_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            #1;
            if (bus.res_valid) seen++;
        end
        vectors++;
        if (seen !== 0) begin
            miscompares++;
            $display("FAIL rst_mid_novalid: valid cycles=%0d req 0", seen);
        end
        check_req("rst_after", 16'h1234, 16'h1234, 1'b0);
    endtask

    task automatic test_fault;
        int         lat;
        int         n;
        logic [3:0] fl;
        logic       err;
        @(negedge clk);
        bus.start_valid = 1'b1;
        bus.a = 16'h1234;
        bus.b = 16'h1234;
        bus.signed_mode = 1'b0;
        @(posedge clk);
        #1;
        bus.start_valid = 1'b0;
        @(posedge clk);
        #1;
        inj_val = 4'b0110;
        inj = 1'b1;
        @(posedge clk);
        #1;
        inj = 1'b0;
        vectors++;
        if (bus.res_valid !== 1'b1 || bus.res_err !== 1'b1 ||
            bus.res_flags !== 4'h0 || bus.res_count !== 3'd2) begin
            miscompares++;
            $display("FAIL fault: vld=%b err=%b fl=%b cnt=%0d req 1 1 0000 2",
                     bus.res_valid, bus.res_err, bus.res_flags, bus.res_count);
        end
        @(posedge clk);
        #1;
        do_req(16'h0F00, 16'h0E00, 1'b0, lat, fl, n, err);
        vectors++;
        if (err !== 1'b0 || fl !== 4'b0100 || n !== 2 || lat !== 2) begin
            miscompares++;
            $display("FAIL fault_clear: err=%b fl=%b cnt=%0d lat=%0d req 0 0100 2 2",
                     err, fl, n, lat);
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        inj = 1'b0;
        inj_val = 4'h0;
        bus.start_valid = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.signed_mode = 1'b0;
        bus.res_ready = 1'b1;
        rst_n = 1'b0;
        #12;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        test_directed();
        test_random();
        test_backpressure();
        test_reset_mid();
        test_fault();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
